// File: rtl/pool_buf_pkg.sv
// pool_buf_pkg: geometry shared by the layer-buffer RAM controllers.
package pool_buf_pkg;
   localparam int DATA_W = 128;
   localparam int ADDR_W = 11;
   localparam int RD_LAT = 2;
   localparam int DEPTH  = 1 << ADDR_W;
   typedef logic [ADDR_W:0] ptr_t;
endpackage

// File: rtl/pool_skid_fifo.sv
// pool_skid_fifo: shallow register FIFO catching RAM read data so the consumer can stall.
module pool_skid_fifo #(
   parameter int W = 128,
   parameter int D = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  logic [W-1:0]           i_din,
   input  logic                   i_pop,
   output logic                   o_valid,
   output logic [W-1:0]           o_dout,
   output logic [$clog2(D+1)-1:0] o_cnt
);
   localparam int CW = $clog2(D + 1);
   localparam int IW = $clog2(D);
   logic [W-1:0]  r_mem [D];
   logic [IW-1:0] r_rd, r_wr;
   logic [CW-1:0] r_cnt;
   function automatic logic [IW-1:0] f_nxt(input logic [IW-1:0] i);
      return (i == IW'(D - 1)) ? '0 : i + IW'(1);
   endfunction
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr] <= i_din;
            r_wr        <= f_nxt(r_wr);
         end
         if (i_pop) r_rd <= f_nxt(r_rd);
         r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
      end
   end
   assign o_valid = r_cnt != '0;
   assign o_dout  = r_mem[r_rd];
   assign o_cnt   = r_cnt;
   // the parent's read-credit rule must keep this from ever firing
   a_no_ovf: assert property (@(posedge clk) disable iff (rst) !(i_push && !i_pop && r_cnt == CW'(D)));
endmodule

// File: rtl/pool1_rm_fifo_ctrl.sv
// pool1_rm_fifo_ctrl: valid/ready FIFO sequencing the pool1 row-major SDP RAM,
// with in-flight read credit accounting and an output skid buffer.
module pool1_rm_fifo_ctrl #(
   parameter int DATA_W = pool_buf_pkg::DATA_W,
   parameter int ADDR_W = pool_buf_pkg::ADDR_W,
   parameter int RD_LAT = pool_buf_pkg::RD_LAT,
   parameter int SKID_D = RD_LAT + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_flush,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [DATA_W-1:0] i_in_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic [ADDR_W:0]   o_level,
   output logic              o_ram_wea,
   output logic [ADDR_W-1:0] o_ram_addra,
   output logic [DATA_W-1:0] o_ram_dina,
   output logic [ADDR_W-1:0] o_ram_addrb,
   input  logic [DATA_W-1:0] i_ram_doutb
);
   localparam int PW = ADDR_W + 1;
   localparam int CNT_W = $clog2(SKID_D + 1);
   localparam logic [PW-1:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [PW-1:0] SKID_L = PW'(SKID_D);
   logic [PW-1:0]     r_wr_ptr, r_rd_ptr, w_stored, w_infl, w_occ;
   logic [RD_LAT-1:0] r_rd_pipe;
   logic [ADDR_W-1:0] r_addrb;
   logic [CNT_W-1:0]  w_sk_cnt;
   logic              w_clr, w_full, w_empty, w_wr, w_pop, w_issue;
   always_comb begin
      w_infl = '0;
      for (int k = 0; k < RD_LAT; k++) w_infl = w_infl + PW'(r_rd_pipe[k]);
   end
   assign w_clr      = rst || i_flush;
   assign w_stored   = r_wr_ptr - r_rd_ptr;
   assign w_full     = w_stored == DEPTH_L;
   assign w_empty    = w_stored == '0;
   assign o_in_ready = !w_clr && !w_full;
   assign w_wr       = i_in_valid && o_in_ready;
   assign w_pop      = o_out_valid && i_out_ready;
   // reads in flight plus skid words, after this cycle's pop, must leave room in the skid
   assign w_occ      = w_infl + PW'(w_sk_cnt) - PW'(w_pop);
   assign w_issue    = !w_clr && !w_empty && (w_occ < SKID_L);
   assign o_ram_wea   = w_wr;
   assign o_ram_addra = r_wr_ptr[ADDR_W-1:0];
   assign o_ram_dina  = i_in_data;
   assign o_ram_addrb = w_issue ? r_rd_ptr[ADDR_W-1:0] : r_addrb;
   assign o_level     = w_stored + w_infl + PW'(w_sk_cnt);
   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_rd_pipe <= '0;
         r_addrb   <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_issue) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
            r_addrb  <= r_rd_ptr[ADDR_W-1:0];
         end
         r_rd_pipe <= RD_LAT'({r_rd_pipe, w_issue});
      end
   end
   pool_skid_fifo #(.W(DATA_W), .D(SKID_D)) u_skid (
      .clk     (clk),
      .rst     (w_clr),
      .i_push  (r_rd_pipe[RD_LAT-1]),
      .i_din   (i_ram_doutb),
      .i_pop   (w_pop),
      .o_valid (o_out_valid),
      .o_dout  (o_out_data),
      .o_cnt   (w_sk_cnt)
   );
endmodule

// File: tb/tb_pool1_rm_fifo_ctrl.sv
// tb_pool1_rm_fifo_ctrl: scoreboard bench with a behavioural RAM and an ordered word queue as reference.
module tb_pool1_rm_fifo_ctrl;
   logic clk = 1'b0;
   logic rst, flush, in_valid, in_ready, out_valid, out_ready, ram_wea;
   logic [127:0] in_data, out_data, ram_dina, ram_doutb;
   logic [11:0]  level;
   logic [10:0]  ram_addra, ram_addrb;
   logic [127:0] mem [2048];
   logic [127:0] s1, s2;
   logic [127:0] sb [$];
   int checks = 0, failures = 0, cyc = 0, pop_total = 0;
   bit mon_en = 1'b0;

   always #5 clk = ~clk;

   pool1_rm_fifo_ctrl dut (
      .clk(clk), .rst(rst), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_in_data(in_data), .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
      .o_level(level), .o_ram_wea(ram_wea), .o_ram_addra(ram_addra), .o_ram_dina(ram_dina),
      .o_ram_addrb(ram_addrb), .i_ram_doutb(ram_doutb)
   );

   // two-register read path: address sampled at the edge, data two edges later
   always @(posedge clk) begin
      if (ram_wea) mem[ram_addra] <= ram_dina;
      s1  <= mem[ram_addrb];
      s2  <= s1;
      cyc <= cyc + 1;
   end
   assign ram_doutb = s2;

   task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", n, act, exp, cyc);
      end
   endtask

   function automatic logic [127:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // monitor: level is words accepted minus words delivered; every delivery must match queue head
   always @(negedge clk) if (mon_en) begin
      chk("level", 128'(level), 128'(sb.size()));
      if (!rst && !flush && sb.size() < 2048) chk("in_ready_room", 128'(in_ready), 128'(1));
      if (sb.size() >= 2051) chk("in_ready_full", 128'(in_ready), 128'(0));
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_empty got=pop exp=no_pop (cycle %0d)", cyc);
         end else chk("out_data", out_data, sb.pop_front());
         pop_total++;
      end
   end

   task automatic step(output bit acc);
      @(negedge clk);
      #1;
      acc = in_valid && in_ready && !rst && !flush;
      if (rst || flush) sb.delete();
      else if (acc) sb.push_back(in_data);
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int bound);
      bit a;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < bound && sb.size() != 0; c++) step(a);
      chk("drain_left", 128'(sb.size()), 128'(0));
      step(a);
      chk("drain_out_valid", 128'(out_valid), 128'(0));
   endtask

   initial begin
      bit a;
      int n, base, bub, tw;
      bit seen;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = '1; out_ready = 1'b1;
      repeat (3) begin
         step(a);
         chk("rst_in_ready", 128'(in_ready), 128'(0));
         chk("rst_wea", 128'(ram_wea), 128'(0));
      end
      rst = 1'b0; in_valid = 1'b0;
      #1;
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_level", 128'(level), 128'(0));
      chk("rst_addrb", 128'(ram_addrb), 128'(0));
      chk("rst_in_ready_after", 128'(in_ready), 128'(1));
      mon_en = 1'b1;
      repeat (2) step(a);
      // single word latency
      in_valid = 1'b1; in_data = {16{8'hA5}}; tw = cyc;
      step(a);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 10) begin step(a); n++; end
      chk("lat_cycles", 128'(cyc - tw), 128'(4));
      chk("lat_data", out_data, {16{8'hA5}});
      chk("lat_level1", 128'(level), 128'(1));
      step(a);
      chk("lat_level0", 128'(level), 128'(0));
      // 4096-word stream, no stalls: crosses pointer wrap twice
      base = pop_total; n = 0; bub = 0; seen = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 6000 && pop_total - base < 4096; c++) begin
         in_valid = n < 4096;
         in_data  = 128'(n);
         step(a);
         if (a) n++;
         if (out_valid) seen = 1'b1;
         else if (seen && pop_total - base < 4096) bub++;
      end
      in_valid = 1'b0;
      chk("stream_sent", 128'(n), 128'(4096));
      chk("stream_pops", 128'(pop_total - base), 128'(4096));
      chk("stream_bubbles", 128'(bub), 128'(0));
      // fill with consumer stalled
      in_valid = 1'b1; out_ready = 1'b0; n = 0;
      for (int c = 0; c < 2100; c++) begin
         in_data = rnd();
         step(a);
         if (a) n++;
      end
      in_valid = 1'b0;
      #1;
      chk("fill_accepted", 128'(n), 128'(2051));
      chk("fill_in_ready", 128'(in_ready), 128'(0));
      chk("fill_level", 128'(level), 128'(2051));
      out_ready = 1'b1;
      step(a);
      out_ready = 1'b0;
      #1;
      chk("fill_ready_after_pop", 128'(in_ready), 128'(1));
      drain(2300);
      // random traffic
      for (int c = 0; c < 10000; c++) begin
         in_valid  = $urandom_range(99) < 70;
         out_ready = $urandom_range(1) == 1;
         in_data   = rnd();
         step(a);
      end
      drain(2300);
      // flush with 100 words stored and reads in flight
      out_ready = 1'b0; in_valid = 1'b1; n = 0;
      for (int c = 0; c < 200 && n < 100; c++) begin
         in_data = rnd();
         step(a);
         if (a) n++;
      end
      in_valid = 1'b0;
      repeat (5) step(a);
      out_ready = 1'b1;
      repeat (2) step(a);
      out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1; in_data = rnd();
      step(a);
      flush = 1'b0; in_valid = 1'b0;
      #1;
      chk("flush_level", 128'(level), 128'(0));
      chk("flush_out_valid", 128'(out_valid), 128'(0));
      in_valid = 1'b1; in_data = 128'hF00;
      #1;
      chk("flush_addra", 128'(ram_addra), 128'(0));
      chk("flush_wea", 128'(ram_wea), 128'(1));
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = 128'hF00 + 128'(i);
         step(a);
      end
      drain(50);
      // reset mid-stream with a write pending
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = rnd();
         step(a);
      end
      rst = 1'b1; in_data = rnd();
      #1;
      chk("rst_mid_wea", 128'(ram_wea), 128'(0));
      chk("rst_mid_in_ready", 128'(in_ready), 128'(0));
      step(a);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      chk("rst_mid_level", 128'(level), 128'(0));
      chk("rst_mid_out_valid", 128'(out_valid), 128'(0));
      chk("rst_mid_addrb", 128'(ram_addrb), 128'(0));
      chk("rst_mid_in_ready_after", 128'(in_ready), 128'(1));
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_data = rnd();
         step(a);
      end
      drain(50);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
